// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: merges execute writebacks with load results,
// buffering up to two loads, killing WAW-stale loads and flagging head starvation.
module rf_wb_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ex_valid_i,
  input  logic [4:0]  ex_rd_add_i,
  input  logic [31:0] ex_rd_data_i,
  input  logic        ld_valid_i,
  output logic        ld_ready_o,
  input  logic [4:0]  ld_rd_add_i,
  input  logic [31:0] ld_rd_data_i,
  output logic        we_o,
  output logic [4:0]  rd_add_o,
  output logic [31:0] rd_data_o,
  output logic [31:0] pend_o,
  output logic        stall_o,
  output logic        err_o
);

  localparam logic [3:0] AGE_MAX = 4'(STARVE_MAX);

  typedef struct packed {
    logic [4:0]  add;
    logic [31:0] data;
  } entry_t;

  // Slot 0 is always the head; a valid slot 1 implies a valid slot 0.
  entry_t      ent_q [2];
  entry_t      ent_d [2];
  logic [1:0]  vld_q, vld_d;
  logic [3:0]  age_q, age_d;
  logic        stall_q, stall_d;
  logic        err_q, err_d;

  logic        ex_req;
  logic        ld_acc;
  logic        ld_live;
  logic [1:0]  kill;
  logic [1:0]  surv;
  logic        pop;
  logic        bypass;
  logic        push;
  logic        head_stays;
  entry_t      ld_ent;

  assign ld_ready_o = ~vld_q[1];
  assign ex_req     = ex_valid_i && (ex_rd_add_i != 5'd0);
  assign ld_acc     = ld_valid_i && ld_ready_o;
  // A same-cycle load to the register execute is writing is older, so it dies.
  assign ld_live    = ld_acc && (ld_rd_add_i != 5'd0) &&
                      !(ex_req && (ld_rd_add_i == ex_rd_add_i));
  assign ld_ent     = '{add: ld_rd_add_i, data: ld_rd_data_i};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      kill[i] = vld_q[i] && ex_req && (ent_q[i].add == ex_rd_add_i);
    end
  end

  assign surv       = vld_q & ~kill;
  assign pop        = !ex_req && vld_q[0];
  assign bypass     = !ex_req && !vld_q[0] && ld_live;
  assign push       = ld_live && !bypass;
  assign head_stays = vld_q[0] && ex_req && !kill[0];

  // NOTE: combinational blocks use blocking '=' with a default for every output
  // first, so no latch is inferred; state registers below use non-blocking '<='.
  always_comb begin
    ent_d = ent_q;
    vld_d = 2'b00;
    if (pop) begin
      ent_d[0] = ent_q[1];
      vld_d[0] = vld_q[1];
    end else if (surv[0]) begin
      vld_d = surv;
    end else begin
      ent_d[0] = ent_q[1];
      vld_d[0] = surv[1];
    end
    if (push) begin
      if (!vld_d[0]) begin
        ent_d[0] = ld_ent;
        vld_d[0] = 1'b1;
      end else begin
        ent_d[1] = ld_ent;
        vld_d[1] = 1'b1;
      end
    end
  end

  always_comb begin
    age_d = 4'd0;
    if (head_stays) begin
      age_d = (age_q == AGE_MAX) ? age_q : age_q + 4'd1;
    end
    stall_d = (age_d == AGE_MAX);
    err_d   = err_q | (ex_req & stall_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q   <= 2'b00;
      age_q   <= 4'd0;
      stall_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      vld_q   <= vld_d;
      age_q   <= age_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  // NOTE: payload storage needs no reset; the valid bits alone decide whether
  // a slot is meaningful, so clearing the data would only cost reset fanout.
  always_ff @(posedge clk_i) begin
    ent_q <= ent_d;
  end

  always_comb begin
    we_o      = 1'b0;
    rd_add_o  = 5'd0;
    rd_data_o = 32'd0;
    if (!rst_i) begin
      if (ex_req) begin
        we_o      = 1'b1;
        rd_add_o  = ex_rd_add_i;
        rd_data_o = ex_rd_data_i;
      end else if (pop) begin
        we_o      = 1'b1;
        rd_add_o  = ent_q[0].add;
        rd_data_o = ent_q[0].data;
      end else if (bypass) begin
        we_o      = 1'b1;
        rd_add_o  = ld_rd_add_i;
        rd_data_o = ld_rd_data_i;
      end
    end
  end

  // Pending mask reflects the FIFO contents as they stand after this cycle.
  always_comb begin
    pend_o = 32'd0;
    if (!rst_i) begin
      for (int i = 0; i < 2; i++) begin
        if (vld_d[i]) pend_o[ent_d[i].add] = 1'b1;
      end
    end
    pend_o[0] = 1'b0;
  end

  assign stall_o = stall_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_rf_wb_arbiter;

  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic [4:0]  ex_add = '0;
  logic [31:0] ex_data = '0;
  logic        ld_valid = 1'b0;
  logic [4:0]  ld_add = '0;
  logic [31:0] ld_data = '0;
  logic        ld_ready, we, stall, err;
  logic [4:0]  rd_add;
  logic [31:0] rd_data, pend;

  rf_wb_arbiter #(.STARVE_MAX(MAX)) dut (
    .clk_i(clk), .rst_i(rst),
    .ex_valid_i(ex_valid), .ex_rd_add_i(ex_add), .ex_rd_data_i(ex_data),
    .ld_valid_i(ld_valid), .ld_ready_o(ld_ready),
    .ld_rd_add_i(ld_add), .ld_rd_data_i(ld_data),
    .we_o(we), .rd_add_o(rd_add), .rd_data_o(rd_data),
    .pend_o(pend), .stall_o(stall), .err_o(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: an ordered list of buffered loads plus age/stall/err.
  typedef struct packed {
    logic [4:0]  add;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  ent_t        nq[$];
  int          age = 0;
  bit          stall_m = 0;
  bit          err_m = 0;
  logic        m_we;
  logic [4:0]  m_add;
  logic [31:0] m_data;
  logic [31:0] m_pend;
  int          m_age_n;
  bit          m_stall_n, m_err_n;

  task automatic model_eval();
    bit ex_req, live, byp, head_same;
    ex_req = ex_valid && (ex_add != 0);
    live   = ld_valid && (q.size() < 2) && (ld_add != 0) && !(ex_req && ld_add == ex_add);
    byp    = 0;
    m_we = 0; m_add = 0; m_data = 0;
    nq.delete();
    foreach (q[i]) if (!(ex_req && q[i].add == ex_add)) nq.push_back(q[i]);
    if (ex_req) begin
      m_we = 1; m_add = ex_add; m_data = ex_data;
    end else if (q.size() > 0) begin
      m_we = 1; m_add = q[0].add; m_data = q[0].data;
      void'(nq.pop_front());
    end else if (live) begin
      m_we = 1; m_add = ld_add; m_data = ld_data; byp = 1;
    end
    if (live && !byp) nq.push_back(ent_t'{add: ld_add, data: ld_data});
    m_pend = 0;
    foreach (nq[i]) m_pend[nq[i].add] = 1'b1;
    // The head survives unchanged only if execute took the port and did not kill it.
    head_same = (q.size() > 0) && ex_req && (q[0].add != ex_add);
    m_age_n   = head_same ? ((age + 1 > MAX) ? MAX : age + 1) : 0;
    m_stall_n = (m_age_n == MAX);
    m_err_n   = err_m || (ex_req && stall_m);
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      q.delete(); age = 0; stall_m = 0; err_m = 0;
    end else begin
      model_eval();
      q = nq; age = m_age_n; stall_m = m_stall_n; err_m = m_err_n;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst) begin
      check("rst_we", 32'(we), 32'd0);
      check("rst_pend", pend, 32'd0);
      check("rst_ready", 32'(ld_ready), 32'd1);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_err", 32'(err), 32'd0);
    end else begin
      model_eval();
      check("we", 32'(we), 32'(m_we));
      check("rd_add", 32'(rd_add), 32'(m_add));
      check("rd_data", rd_data, m_data);
      check("pend", pend, m_pend);
      check("ld_ready", 32'(ld_ready), 32'(q.size() < 2));
      check("stall", 32'(stall), 32'(stall_m));
      check("err", 32'(err), 32'(err_m));
    end
  end

  task automatic step(input bit exv, input logic [4:0] exa, input logic [31:0] exd,
                      input bit lv, input logic [4:0] la, input logic [31:0] ldd);
    @(posedge clk); #1;
    ex_valid = exv; ex_add = exa; ex_data = exd;
    ld_valid = lv;  ld_add = la;  ld_data = ldd;
    @(negedge clk); #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("lit_reset_ready", 32'(ld_ready), 32'd1);
    check("lit_reset_we", 32'(we), 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // Bypass of an idle load.
    step(0, 0, 0, 1, 5, 32'hA5A5_A5A5);
    check("lit_bypass_we", 32'(we), 32'd1);
    check("lit_bypass_add", 32'(rd_add), 32'd5);
    check("lit_bypass_pend", pend, 32'd0);
    idle();

    // Execute wins, load buffered then drained.
    step(1, 3, 32'h33, 1, 7, 32'h77);
    check("lit_ex_first_add", 32'(rd_add), 32'd3);
    check("lit_ex_first_pend", pend, 32'h0000_0080);
    idle();
    check("lit_ld_second_add", 32'(rd_add), 32'd7);
    check("lit_ld_second_data", rd_data, 32'h77);
    check("lit_ld_second_pend", pend, 32'd0);
    idle();

    // Pop and push together at one entry.
    step(1, 3, 32'h3, 1, 7, 32'h77);
    step(0, 0, 0, 1, 9, 32'h99);
    check("lit_popush_add", 32'(rd_add), 32'd7);
    check("lit_popush_pend", pend, 32'h0000_0200);
    idle();
    check("lit_popush_drain", 32'(rd_add), 32'd9);
    idle();

    // Fill, starve, stall, error.
    step(1, 10, 32'h10, 1, 8, 32'h88);
    step(1, 11, 32'h11, 1, 9, 32'h99);
    step(1, 12, 32'h12, 1, 13, 32'hDD);
    check("lit_full_ready", 32'(ld_ready), 32'd0);
    check("lit_full_pend", pend, 32'h0000_0300);
    step(1, 14, 32'h14, 0, 0, 0);
    step(1, 16, 32'h16, 0, 0, 0);
    check("lit_stall_not_yet", 32'(stall), 32'd0);
    step(1, 17, 32'h17, 0, 0, 0);
    check("lit_stall_high", 32'(stall), 32'd1);
    check("lit_err_not_yet", 32'(err), 32'd0);
    idle();
    check("lit_err_set", 32'(err), 32'd1);
    check("lit_head_drain", 32'(rd_add), 32'd8);
    idle();
    check("lit_stall_low", 32'(stall), 32'd0);
    idle();

    // WAW kill of a buffered entry.
    step(1, 20, 32'h20, 1, 4, 32'h44);
    step(1, 4, 32'h1234, 0, 0, 0);
    check("lit_kill_data", rd_data, 32'h1234);
    check("lit_kill_pend", pend, 32'd0);
    idle();
    check("lit_kill_nowrite", 32'(we), 32'd0);

    // Same-cycle load to the execute register is dropped.
    step(1, 15, 32'hF, 1, 15, 32'hBAD);
    check("lit_same_rd_pend", pend, 32'd0);
    idle();
    check("lit_same_rd_nowrite", 32'(we), 32'd0);

    // Execute to x0 is no request; the load bypasses.
    step(1, 0, 32'hDEAD, 1, 6, 32'h66);
    check("lit_x0_ex_add", 32'(rd_add), 32'd6);
    check("lit_x0_ex_data", rd_data, 32'h66);

    // Load to x0 is discarded.
    step(0, 0, 0, 1, 0, 32'h1);
    check("lit_ld_x0_we", 32'(we), 32'd0);
    idle();

    // Reset with two entries buffered.
    step(1, 21, 32'h21, 1, 22, 32'h22);
    step(1, 23, 32'h23, 1, 24, 32'h24);
    check("lit_two_pend", pend, 32'h0140_0000);
    @(posedge clk); #1;
    rst = 1'b1; ex_valid = 0; ld_valid = 0;
    @(negedge clk); #1;
    check("lit_midrst_we", 32'(we), 32'd0);
    check("lit_midrst_pend", pend, 32'd0);
    check("lit_midrst_ready", 32'(ld_ready), 32'd1);
    @(posedge clk); #1; rst = 1'b0;
    idle();
    check("lit_post_rst_we", 32'(we), 32'd0);
    check("lit_post_rst_err", 32'(err), 32'd0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_MAX, default 4, legal range 1-15: the number of cycles the head buffered load result may wait before stall_o is raised.
REQ-002 clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  asynchronous, active-high reset.
REQ-004 ex_valid_i  input  1  execute-stage writeback request, with no backpressure.
REQ-005 ex_rd_add_i  input  5  execute destination register.
REQ-006 ex_rd_data_i  input  32  execute writeback data.
REQ-007 ld_valid_i  input  1  load-unit result valid.
REQ-008 ld_ready_o  output  1  load result accepted this cycle when high together with ld_valid_i.
REQ-009 ld_rd_add_i  input  5  load destination register.
REQ-010 ld_rd_data_i  input  32  load data.
REQ-011 we_o  output  1  register-file write enable.
REQ-012 rd_add_o  output  5  register-file write address.
REQ-013 rd_data_o  output  32  register-file write data.
REQ-014 pend_o  output  32  bit n high while a buffered load result for register n is pending; bit 0 always 0.
REQ-015 stall_o  output  1  registered request to the pipeline to withhold execute writebacks.
REQ-016 err_o  output  1  sticky protocol-error flag.

Function
REQ-017 The block SHALL own a 2-entry FIFO of {rd_add, data} for load results and a head-age counter.
REQ-018 ld_ready_o SHALL be high exactly when the FIFO holds fewer than 2 entries (combinational from state).
REQ-019 An execute request with ex_rd_add_i = 0 SHALL be treated as no request.
REQ-020 An accepted load with ld_rd_add_i = 0 SHALL be discarded without using the port or the FIFO.
REQ-021 Port priority each cycle SHALL be: execute request, then FIFO head, then the incoming accepted load (bypass); at most one write per cycle.
REQ-022 Bypass: a load accepted with the FIFO empty and no execute request SHALL drive we_o in the same cycle (zero latency) and not enter the FIFO.
REQ-023 An accepted load that does not win the port SHALL be pushed to the FIFO tail; FIFO order is preserved.
REQ-024 A simultaneous pop and push at 2 entries is impossible, because ld_ready_o is low; at 1 entry the pop and push SHALL both occur and leave the count at 1.
REQ-025 WAW kill: an execute write to register r SHALL invalidate every buffered entry with rd_add = r in that same cycle; killed entries are removed without a write.
REQ-026 WAW kill: a load accepted in the same cycle with rd = r is older and SHALL also be discarded.
REQ-027 pend_o SHALL be the OR of the one-hot decodes of the valid FIFO entries, updated with the FIFO state.
REQ-028 The age counter SHALL clear when the head changes or the FIFO empties, and otherwise increment, saturating at STARVE_MAX, on each cycle the head is not written.
REQ-029 stall_o SHALL be registered high the cycle after age reaches STARVE_MAX, and registered low the cycle after the head is written or the FIFO empties.
REQ-030 An execute request while stall_o is high SHALL still win the port and SHALL set err_o, which stays high until reset.
REQ-031 When we_o is low, rd_add_o and rd_data_o SHALL be 0.

Reset
REQ-032 While rst_i is high: FIFO empty, age 0, stall_o 0, err_o 0, pend_o 0, we_o 0, ld_ready_o 1.
REQ-033 Reset asserted mid-operation SHALL discard buffered entries without writing them.
REQ-034 The first write after rst_i deasserts SHALL occur no earlier than the first rising edge at which rst_i is low.

Verification
REQ-035 Idle, load rd=5 data=0xA5A5A5A5 -> we_o=1, rd_add_o=5 in the same cycle; pend_o stays 0.
REQ-036 Execute rd=3 and load rd=7 in the same cycle -> cycle 0 writes x3 with pend_o[7]=1; cycle 1 writes x7 and pend_o=0.
REQ-037 Execute writes every cycle for 3 cycles while loads rd=8 and rd=9 arrive -> ld_ready_o low after 2 entries.
REQ-038 With STARVE_MAX=4 and execute writes continuing -> stall_o rises on the 5th cycle; an execute write while stall_o=1 sets err_o.
REQ-039 Buffered load rd=4, then execute rd=4 -> the entry is killed, pend_o[4] drops, and x4 is never written with the load data.
REQ-040 Load rd=0 -> accepted, no write; pulse rst_i with 2 entries buffered -> no writes, pend_o=0, ld_ready_o=1.
